// File: rtl/f1_light_seq_pkg.sv
// Shared types and constants for the f1_light_seq start-light sequencer.
// The LFSR tap table is used only when F1_RANDOM_DELAY_EN is defined.
package f1_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_N_LIGHTS    = 8;
  localparam int DEF_LFSR_WIDTH  = 7;
  localparam int DEF_FIXED_DELAY = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LIGHTS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // In the returned mask, bit i stands for the x^(i+1) term of a maximal-length polynomial.
  function automatic logic [7:0] lfsr_taps(input int w);
    logic [7:0] taps;
    case (w)
      4:       taps = 8'h0C;  // x^4+x^3+1
      5:       taps = 8'h14;  // x^5+x^3+1
      6:       taps = 8'h30;  // x^6+x^5+1
      7:       taps = 8'h60;  // x^7+x^6+1
      8:       taps = 8'hB8;  // x^8+x^6+x^5+x^4+1
      default: taps = 8'h60;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/f1_light_seq_if.sv
// Control and status bundle between the display wrapper and f1_light_seq.
interface f1_light_seq_if #(
  parameter int WIDTH    = 16,
  parameter int N_LIGHTS = 8
) ();

  logic                trigger;
  logic                abort;
  logic [WIDTH-1:0]    N;
  logic [N_LIGHTS-1:0] data_out;
  logic                busy;
  logic                lights_out;

  modport master (
    output trigger, abort, N,
    input  data_out, busy, lights_out
  );

  modport slave (
    input  trigger, abort, N,
    output data_out, busy, lights_out
  );

endinterface

// File: rtl/f1_light_seq_tick_gen.sv
// Reloadable down-counter that emits a tick whenever an enabled count reaches zero.
module tick_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] reload,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_r;

  assign tick = en && (cnt_r == {WIDTH{1'b0}});

  // Load takes priority over everything else. Disabled means the count is parked at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= reload;
    end else if (!en) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (cnt_r == {WIDTH{1'b0}}) begin
      cnt_r <= reload;
    end else begin
      cnt_r <= cnt_r - WIDTH'(1);
    end
  end

endmodule

// File: rtl/f1_light_seq.sv
// Start-light sequencer: lights come on one per tick, hold for a delay, then all go off together.
// Define F1_RANDOM_DELAY_EN to take the hold delay from an inline LFSR instead of FIXED_DELAY.
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int N_LIGHTS    = DEF_N_LIGHTS,
  parameter int LFSR_WIDTH  = DEF_LFSR_WIDTH,
  parameter int FIXED_DELAY = DEF_FIXED_DELAY
) (
  input logic           clk,
  input logic           rst,
  f1_light_seq_if.slave bus
);

  state_t              state_r, state_s;
  logic [N_LIGHTS-1:0] data_r, data_s;
  logic [31:0]         delay_r, delay_s;
  logic [31:0]         dly_init_s;
  logic                busy_r;
  logic                lo_r, lo_s;
  logic                load_s;
  logic                tick_s;

  tick_gen #(.WIDTH(WIDTH)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .en     (busy_r),
    .reload (bus.N),
    .tick   (tick_s)
  );

`ifdef F1_RANDOM_DELAY_EN
  localparam logic [LFSR_WIDTH-1:0] TAPS = LFSR_WIDTH'(lfsr_taps(LFSR_WIDTH));
  logic [LFSR_WIDTH-1:0] lfsr_r;

  // Free-running Fibonacci LFSR. Seed 1 keeps it off the all-zero lock-up state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_r <= LFSR_WIDTH'(1);
    end else begin
      lfsr_r <= {lfsr_r[LFSR_WIDTH-2:0], ^(lfsr_r & TAPS)};
    end
  end

  assign dly_init_s = 32'(lfsr_r);
`else
  assign dly_init_s = 32'(FIXED_DELAY);
`endif

  // Next-state and datapath. Abort overrides trigger and tick.
  always_comb begin
    state_s = state_r;
    data_s  = data_r;
    delay_s = delay_r;
    lo_s    = 1'b0;
    load_s  = 1'b0;
    if (bus.abort) begin
      state_s = IDLE;
      data_s  = {N_LIGHTS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.trigger) begin
            state_s = LIGHTS;
            load_s  = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        LIGHTS: begin
          if (tick_s) begin
            data_s = {data_r[N_LIGHTS-2:0], 1'b1};
            // Bit N_LIGHTS-2 already lit means this tick lights the final bit.
            if (data_r[N_LIGHTS-2]) begin
              state_s = HOLD;
              delay_s = dly_init_s;
            end else begin
              state_s = LIGHTS;
            end
          end else begin
            state_s = LIGHTS;
          end
        end
        HOLD: begin
          if (tick_s) begin
            if (delay_r <= 32'd1) begin
              state_s = IDLE;
              data_s  = {N_LIGHTS{1'b0}};
              lo_s    = 1'b1;
            end else begin
              delay_s = delay_r - 32'd1;
            end
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s = IDLE;
          data_s  = {N_LIGHTS{1'b0}};
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      data_r  <= {N_LIGHTS{1'b0}};
      delay_r <= 32'd0;
      busy_r  <= 1'b0;
      lo_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      data_r  <= data_s;
      delay_r <= delay_s;
      busy_r  <= (state_s != IDLE);
      lo_r    <= lo_s;
    end
  end

  assign bus.data_out   = data_r;
  assign bus.busy       = busy_r;
  assign bus.lights_out = lo_r;

endmodule

// File: tb/tb_f1_light_seq.sv
// Directed bench for f1_light_seq: an 8-light instance plus a 3-light instance.
module tb_f1_light_seq;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   miss_cnt;

  f1_light_seq_if #(.WIDTH(16), .N_LIGHTS(8)) bus ();
  f1_light_seq_if #(.WIDTH(16), .N_LIGHTS(3)) sbus ();

  f1_light_seq #(.WIDTH(16), .N_LIGHTS(8), .LFSR_WIDTH(7), .FIXED_DELAY(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  f1_light_seq #(.WIDTH(16), .N_LIGHTS(3), .LFSR_WIDTH(7), .FIXED_DELAY(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {lights_out, busy, data_out}
  function automatic logic [31:0] snap8();
    return {22'd0, bus.lights_out, bus.busy, bus.data_out};
  endfunction

  function automatic logic [31:0] snap3();
    return {27'd0, sbus.lights_out, sbus.busy, sbus.data_out};
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge t0.
  task automatic fire();
    bus.trigger = 1'b1;
    @(posedge clk);
    #1 bus.trigger = 1'b0;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fixed-delay sequence; mid_trig > 0 pulses trigger into edge t0+mid_trig.
  task automatic run_seq(input int n, input int d, input int mid_trig);
    int off;
    int k;
    logic [31:0] exp;
    bus.N = 16'(n);
    fire();
    chk("seq_start", snap8(), 32'h100);
    off = (8 + d) * (n + 1);
    for (int e = 1; e <= off + 1; e++) begin
      bus.trigger = (e == mid_trig) ? 1'b1 : 1'b0;
      step();
      bus.trigger = 1'b0;
      if (e < off) begin
        k = e / (n + 1);
        if (k > 8) k = 8;
        exp = 32'h100 | ((32'd1 << k) - 32'd1);
      end else if (e == off) begin
        exp = 32'h200;
      end else begin
        exp = 32'h000;
      end
      chk($sformatf("seq_n%0d_e%0d", n, e), snap8(), exp);
    end
  endtask

`ifdef F1_RANDOM_DELAY_EN
  // Random delay: off time must land on a tick boundary with D in 1..127.
  task automatic run_rand(input int n);
    int e;
    int off;
    int d;
    bit seen;
    bus.N = 16'(n);
    fire();
    chk("r_start", snap8(), 32'h100);
    seen = 1'b0;
    off  = 0;
    e    = 0;
    while (!seen && e < 2000) begin
      e++;
      step();
      chk("lfsr_nz", {31'd0, (dut.lfsr_r != 7'd0)}, 32'd1);
      if (e == 8 * (n + 1)) chk("r_full", snap8(), 32'h1FF);
      if (bus.lights_out) begin
        seen = 1'b1;
        off  = e;
      end
    end
    chk("r_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      chk("r_align", 32'(off % (n + 1)), 32'd0);
      d = off / (n + 1) - 8;
      chk("r_drange", {31'd0, (d >= 1 && d <= 127)}, 32'd1);
      chk("r_off", snap8(), 32'h200);
      step();
      chk("r_after", snap8(), 32'h000);
    end
  endtask
`endif

  task automatic full_seq(input int n);
`ifdef F1_RANDOM_DELAY_EN
    run_rand(n);
`else
    run_seq(n, 3, 0);
`endif
  endtask

  initial begin
    logic [31:0] small_exp [8];
    vec_cnt      = 0;
    miss_cnt     = 0;
    rst          = 1'b0;
    bus.trigger  = 1'b0;
    bus.abort    = 1'b0;
    bus.N        = 16'd0;
    sbus.trigger = 1'b0;
    sbus.abort   = 1'b0;
    sbus.N       = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", snap8(), 32'h000);
`ifdef F1_RANDOM_DELAY_EN
    chk("rst_lfsr", {25'd0, dut.lfsr_r}, 32'd1);
`endif
    rst = 1'b1;
    step();

`ifdef F1_RANDOM_DELAY_EN
    for (int i = 0; i < 50; i++) run_rand(i % 2);
`else
    run_seq(0, 3, 0);
    run_seq(4, 3, 12);
    // 3-light instance, N=0, D=3: off at t0+6
    small_exp = '{32'h08, 32'h09, 32'h0B, 32'h0F, 32'h0F, 32'h0F, 32'h10, 32'h00};
    sbus.trigger = 1'b1;
    @(posedge clk);
    #1 sbus.trigger = 1'b0;
    @(negedge clk);
    chk("small_e0", snap3(), small_exp[0]);
    for (int e = 1; e < 8; e++) begin
      step();
      chk($sformatf("small_e%0d", e), snap3(), small_exp[e]);
    end
`endif

    // Asynchronous reset while four lights are lit.
    bus.N = 16'd0;
    fire();
    repeat (4) step();
    chk("pre_rst", snap8(), 32'h10F);
    #2 rst = 1'b0;
    #1 chk("rst_async", snap8(), 32'h000);
    step();
    chk("rst_nopulse", snap8(), 32'h000);
    rst = 1'b1;
    step();
    full_seq(0);

    // Abort in HOLD: everything clears at the next edge, no pulse.
    fire();
    repeat (8) step();
    chk("hold_full", snap8(), 32'h1FF);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_hold", snap8(), 32'h000);
    step();
    chk("abort_nopulse", snap8(), 32'h000);

    // Abort together with trigger in IDLE keeps the block idle.
    bus.abort   = 1'b1;
    bus.trigger = 1'b1;
    step();
    bus.abort   = 1'b0;
    bus.trigger = 1'b0;
    chk("abort_trig_idle", snap8(), 32'h000);
    step();
    chk("abort_trig_idle2", snap8(), 32'h000);

    full_seq(1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/f1_light_seq.md
# f1_light_seq

Parametrised start-light sequencer. A trigger starts the sequence. Lights then switch on one by one, each step paced by an internal clock-tick divider. After all lights are lit, the block waits a hold delay (pseudo-random or fixed) and then switches every light off at once, marking that moment with a one-cycle pulse. It generalises the fixed 8-light, free-running divider-plus-FSM pairing to any light count, adds trigger/abort control and a status output, and sits directly below the top-level display wrapper.

## Interface
Parameters:
- WIDTH, 16, width of divider reload value N
- N_LIGHTS, 8, number of lights (2..32)
- LFSR_WIDTH, 7, random-delay generator width (4..8)
- FIXED_DELAY, 3, hold delay in ticks when random delay is compiled out (≥1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- trigger  in  1  start request, sampled each cycle
- abort  in  1  synchronous abort
- N  in  WIDTH  tick period minus one (one tick every N+1 cycles)
- data_out  out  N_LIGHTS  light pattern; bit 0 lights first
- busy  out  1  high while not IDLE
- lights_out  out  1  one-cycle pulse at the instant all lights go off

## Operation
- States:
  - IDLE → LIGHTS on trigger.
  - LIGHTS → HOLD on the tick that sets the final light.
  - HOLD → IDLE on the tick where the delay counter reaches 0.
  - Any state → IDLE on abort.
- Divider: down-counter.
  - Loaded with N on trigger acceptance.
  - Decrements each cycle while busy.
  - At 0 it asserts tick for one cycle and reloads N.
  - Held at 0 in IDLE.
  - N=0 gives a tick every cycle.
- LIGHTS: on each tick, data_out ← {data_out[N_LIGHTS-2:0],1'b1}. Pattern sequence: 0…01, 0…011, …, all ones.
- HOLD delay D:
  - Captured on the same tick that lights the final bit.
  - Decremented on each subsequent tick.
  - When it reaches 0: data_out ← 0, lights_out pulses, state ← IDLE.
- trigger while busy is ignored. There is no queuing.
- abort has priority over trigger and tick. It clears data_out, returns to IDLE and produces no lights_out pulse. abort and trigger together in IDLE: stay IDLE.
- N is sampled only at each reload. A change mid-sequence takes effect at the next reload.
- LFSR:
  - Free-running Fibonacci LFSR, advances every cycle including IDLE.
  - Reset seed 1. Never all-zero.
  - Captured value lies in 1..2^LFSR_WIDTH−1.

## Timing
- Reset values: data_out=0, busy=0, lights_out=0, state IDLE, divider 0, LFSR=1.
- Reset mid-sequence clears everything immediately (asynchronous) with no pulse.
- Trigger accepted at edge t0: busy=1 from t0.
- k lights are visible from edge t0 + k·(N+1), for k=1..N_LIGHTS.
- Lights off, lights_out=1 and busy=0 all occur at edge t0 + (N_LIGHTS+D)·(N+1). lights_out lasts exactly one cycle.
- A new trigger is accepted in the cycle after busy falls.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- F1_RANDOM_DELAY_EN defined:
  - LFSR instantiated.
  - D is the LFSR value at the capture edge.
- F1_RANDOM_DELAY_EN undefined:
  - No LFSR logic.
  - D = FIXED_DELAY.
  - Sequence is fully deterministic.

## Structure
- Package f1_pkg:
  - State enum (IDLE, LIGHTS, HOLD).
  - LFSR tap-mask constant function indexed by LFSR_WIDTH (4..8; e.g. width 7 → x^7+x^6+1).
  - Default parameter constants.
- Sub-module tick_gen:
  - Reloadable down-counter with load/enable inputs and a tick output.
  - Replaces the free-running divider.
- LFSR stays inline, inside the macro guard.

## Test plan
- Macro off, N=0, N_LIGHTS=8, FIXED_DELAY=3, trigger at t0:
  - data_out=0x01 at t0+1, 0xFF at t0+8.
  - 0x00 with lights_out=1 at t0+11; busy low from t0+11.
- Macro off, N=4:
  - Steps every 5 cycles.
  - 0x03 at t0+10.
  - Off at t0+55.
- Reset edge cases:
  - Reset asserted while data_out=0x0F → all outputs 0 at once, no lights_out pulse.
  - After reset release, the next trigger runs a full sequence.
- Abort and trigger collisions:
  - abort during HOLD → data_out=0, busy=0 next edge, lights_out stays 0.
  - trigger asserted mid-sequence → timing unchanged.
- Macro on, LFSR_WIDTH=7:
  - Across 50 sequences every D lies in 1..127 and the off time matches t0+(8+D)(N+1).
  - LFSR never reads 0.
- N_LIGHTS=3, N=0, macro off: pattern 0b001, 0b011, 0b111, then off at t0+6.
